gpu_apb_command_master: RTL and testbench

// APB initiator that feeds the GPU command port from the host side. It is the transmitting end of the
// APB write path into gpu_apb_interface. Accepts 32-bit instruction words (opcode [31:28], parameters
// [24:0]) over a valid/ready handshake and buffers them in a small FIFO. Issues each word as one APB

---
 rtl/gpu_apb_command_master.sv | 172 +++++++++++++++++
 tb/tb_gpu_apb_command_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_apb_command_master.sv
// APB write initiator for the GPU command port: buffers host instruction words
// in a small FIFO and issues each one as a SETUP/ACCESS write with a wait-state timeout.
module gpu_apb_command_master #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] CMD_ADDR   = 32'h0,
  parameter int unsigned MAX_WAIT   = 15
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic        pReady_i,
  input  logic        pSlvErr_i,
  input  logic        err_clr_i,
  output logic [31:0] pAddr_o,
  output logic [31:0] pDataWrite_o,
  output logic        pSel_o,
  output logic        pEnable_o,
  output logic        pWrite_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          avail_q;
  logic [7:0]    wait_q, wait_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pdata_q, pdata_d;
  logic          err_q, err_d;
  logic          push, pop, set_err;
  logic [31:0]   head;

  assign instr_ready_o = (count_q != CW'(FIFO_DEPTH));
  assign push          = instr_valid_i & instr_ready_o;
  assign head          = mem_q[rd_ptr_q];

  assign pAddr_o      = paddr_q;
  assign pDataWrite_o = pdata_q;
  assign pSel_o       = psel_q;
  assign pEnable_o    = penable_q;
  assign pWrite_o     = psel_q;
  assign err_o        = err_q;
  assign busy_o       = (count_q != '0) || (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= instr_i;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // IDLE launches from a registered non-empty flag, so a freshly pushed word is
  // seen one cycle after it lands; back-to-back chaining in ACCESS uses the live count.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    set_err   = 1'b0;
    wait_d    = wait_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pdata_d   = pdata_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (avail_q && (count_q != '0)) begin
          pop       = 1'b1;
          state_d   = SETUP;
          psel_d    = 1'b1;
          paddr_d   = CMD_ADDR;
          pdata_d   = head;
          wait_d    = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pReady_i) begin
          set_err = pSlvErr_i;
          if (count_q != '0) begin
            pop       = 1'b1;
            state_d   = SETUP;
            penable_d = 1'b0;
            pdata_d   = head;
            wait_d    = '0;
          end else begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else if ((wait_q + 8'd1) == 8'(MAX_WAIT)) begin
          set_err   = 1'b1;
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          wait_d    = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (set_err) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      avail_q   <= 1'b0;
      wait_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q  <= pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_q   <= count_d;
      avail_q   <= (count_q != '0);
      wait_q    <= wait_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_gpu_apb_command_master.sv
// Directed bench for gpu_apb_command_master: latency, back-to-back, back-pressure,
// timeout, slave error and mid-transfer reset, all against hand-computed values.
module tb_gpu_apb_command_master;

  localparam logic [31:0] ADDR = 32'hA000_0010;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic        pReady_i;
  logic        pSlvErr_i;
  logic        err_clr_i;
  logic [31:0] pAddr_o;
  logic [31:0] pDataWrite_o;
  logic        pSel_o;
  logic        pEnable_o;
  logic        pWrite_o;
  logic        busy_o;
  logic        err_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  gpu_apb_command_master #(
    .FIFO_DEPTH(4),
    .CMD_ADDR  (ADDR),
    .MAX_WAIT  (15)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .instr_i      (instr_i),
    .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o),
    .pReady_i     (pReady_i),
    .pSlvErr_i    (pSlvErr_i),
    .err_clr_i    (err_clr_i),
    .pAddr_o      (pAddr_o),
    .pDataWrite_o (pDataWrite_o),
    .pSel_o       (pSel_o),
    .pEnable_o    (pEnable_o),
    .pWrite_o     (pWrite_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    instr_i       = w;
    instr_valid_i = 1'b1;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_access(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pSel_o && pEnable_o) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(found), 32'd1);
  endtask

  logic [31:0] w3 [5];
  logic [31:0] got_q [$];
  logic [31:0] exp_sel [5];
  logic [31:0] exp_en  [5];
  logic [31:0] exp_dat [5];
  int unsigned sel_seen;

  initial begin
    n_rst         = 1'b0;
    instr_i       = '0;
    instr_valid_i = 1'b0;
    pReady_i      = 1'b1;
    pSlvErr_i     = 1'b0;
    err_clr_i     = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(instr_ready_o), 32'd1);
    check("rst_busy",  32'(busy_o),        32'd0);
    check("rst_sel",   32'(pSel_o),        32'd0);
    check("rst_en",    32'(pEnable_o),     32'd0);
    check("rst_addr",  pAddr_o,            32'd0);
    check("rst_data",  pDataWrite_o,       32'd0);
    check("rst_err",   32'(err_o),         32'd0);
    n_rst = 1'b1;
    tick();

    // single zero-wait transfer and launch latency
    push_word(32'h1000_0000);
    check("t1_busy_e0", 32'(busy_o), 32'd1);
    check("t1_sel_e0",  32'(pSel_o), 32'd0);
    tick();
    check("t1_sel_e1",  32'(pSel_o), 32'd0);
    tick();
    check("t1_sel_e2",  32'(pSel_o),    32'd1);
    check("t1_en_e2",   32'(pEnable_o), 32'd0);
    check("t1_wr_e2",   32'(pWrite_o),  32'd1);
    check("t1_addr",    pAddr_o,        ADDR);
    check("t1_data",    pDataWrite_o,   32'h1000_0000);
    tick();
    check("t1_sel_acc", 32'(pSel_o),    32'd1);
    check("t1_en_acc",  32'(pEnable_o), 32'd1);
    tick();
    check("t1_sel_end", 32'(pSel_o),    32'd0);
    check("t1_en_end",  32'(pEnable_o), 32'd0);
    check("t1_wr_end",  32'(pWrite_o),  32'd0);
    check("t1_busy_end", 32'(busy_o),   32'd0);
    check("t1_data_hold", pDataWrite_o, 32'h1000_0000);
    check("t1_addr_hold", pAddr_o,      ADDR);

    // two words back to back
    exp_sel = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0};
    exp_en  = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    exp_dat = '{32'h2000_1807, 32'h2000_1807, 32'h40AA_BD3E, 32'h40AA_BD3E, 32'h40AA_BD3E};
    instr_valid_i = 1'b1;
    instr_i       = 32'h2000_1807;
    tick();
    instr_i       = 32'h40AA_BD3E;
    tick();
    instr_valid_i = 1'b0;
    check("t2_sel_pre", 32'(pSel_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t2_sel_%0d", i), 32'(pSel_o),    exp_sel[i]);
      check($sformatf("t2_en_%0d", i),  32'(pEnable_o), exp_en[i]);
      check($sformatf("t2_dat_%0d", i), pDataWrite_o,   exp_dat[i]);
    end
    check("t2_busy_end", 32'(busy_o), 32'd0);

    // back-pressure with a stalled slave
    w3 = '{32'h1000_00A1, 32'h2012_3456, 32'h3FFF_FFFF, 32'h4000_0000, 32'hF1FF_FFFF};
    pReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_ready_before_%0d", i), 32'(instr_ready_o), 32'd1);
      instr_i       = w3[i];
      instr_valid_i = 1'b1;
      tick();
    end
    check("t3_ready_full", 32'(instr_ready_o), 32'd0);
    instr_i = 32'hDEAD_BEEF;
    tick();
    instr_valid_i = 1'b0;
    check("t3_ready_still_full", 32'(instr_ready_o), 32'd0);
    check("t3_stalled_en", 32'(pEnable_o), 32'd1);
    pReady_i = 1'b1;
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      if (pSel_o && pEnable_o && pReady_i) got_q.push_back(pDataWrite_o);
      if (!busy_o) break;
      tick();
    end
    check("t3_busy_end", 32'(busy_o), 32'd0);
    check("t3_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got_q.size()) check($sformatf("t3_word_%0d", i), got_q[i], w3[i]);
    end
    check("t3_err", 32'(err_o), 32'd0);

    // wait-state timeout
    pReady_i = 1'b0;
    push_word(32'h3000_0001);
    wait_access("t4_reach_access");
    for (int i = 0; i < 14; i++) tick();
    check("t4_en_at_14", 32'(pEnable_o), 32'd1);
    check("t4_err_at_14", 32'(err_o),    32'd0);
    tick();
    check("t4_sel_abort", 32'(pSel_o),  32'd0);
    check("t4_err_abort", 32'(err_o),   32'd1);
    check("t4_busy_abort", 32'(busy_o), 32'd0);
    tick();
    check("t4_err_sticky", 32'(err_o),  32'd1);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("t4_err_clr", 32'(err_o), 32'd0);

    // slave error, following word still transfers; set beats clear
    pReady_i  = 1'b1;
    pSlvErr_i = 1'b1;
    instr_valid_i = 1'b1;
    instr_i       = 32'h5000_00AA;
    tick();
    instr_i       = 32'h6000_00BB;
    tick();
    instr_valid_i = 1'b0;
    wait_access("t5_reach_access");
    check("t5_first_data", pDataWrite_o, 32'h5000_00AA);
    tick();
    check("t5_err_set",   32'(err_o),     32'd1);
    check("t5_next_sel",  32'(pSel_o),    32'd1);
    check("t5_next_en",   32'(pEnable_o), 32'd0);
    check("t5_next_data", pDataWrite_o,   32'h6000_00BB);
    pSlvErr_i = 1'b0;
    err_clr_i = 1'b1;
    tick();
    check("t5_err_cleared", 32'(err_o),     32'd0);
    check("t5_next_acc",    32'(pEnable_o), 32'd1);
    pSlvErr_i = 1'b1;
    tick();
    check("t5_err_priority", 32'(err_o),  32'd1);
    check("t5_busy_end",     32'(busy_o), 32'd0);
    pSlvErr_i = 1'b0;
    tick();
    err_clr_i = 1'b0;
    check("t5_err_final", 32'(err_o), 32'd0);

    // reset during ACCESS with words queued
    pReady_i = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h7000_0000 + 32'(i));
    check("t6_pre_en", 32'(pEnable_o), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_sel",   32'(pSel_o),        32'd0);
    check("t6_en",    32'(pEnable_o),     32'd0);
    check("t6_ready", 32'(instr_ready_o), 32'd1);
    check("t6_busy",  32'(busy_o),        32'd0);
    check("t6_err",   32'(err_o),         32'd0);
    pReady_i = 1'b1;
    tick();
    n_rst = 1'b1;
    sel_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pSel_o) sel_seen++;
    end
    check("t6_no_transfer", 32'(sel_seen), 32'd0);
    check("t6_busy_after",  32'(busy_o),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
